// File: rtl/depq_scan.sv
// Double-ended priority queue: dequeue the minimum or the maximum tag.
// After each dequeue the min/max pointers are rebuilt by a serial scan, one slot per cycle.
module depq_scan #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 32,
    parameter int DEPTH      = 8
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      flush_in,
    input  logic                      enq_valid_in,
    output logic                      enq_ready_out,
    input  logic [DATA_WIDTH-1:0]     enq_data_in,
    input  logic [TAG_WIDTH-1:0]      enq_tag_in,
    input  logic                      deq_valid_in,
    input  logic                      deq_max_in,
    output logic                      deq_ready_out,
    output logic                      valid_out,
    output logic [DATA_WIDTH-1:0]     data_out,
    output logic [TAG_WIDTH-1:0]      tag_out,
    output logic [TAG_WIDTH-1:0]      min_tag_out,
    output logic [TAG_WIDTH-1:0]      max_tag_out,
    output logic [$clog2(DEPTH):0]    size_out,
    output logic                      empty_out,
    output logic                      full_out,
    output logic                      busy_out
);

    localparam int PW = $clog2(DEPTH);
    localparam int SW = PW + 1;

    typedef enum logic {IDLE, SCAN} state_t;

    state_t                state_q, state_d;
    logic [DEPTH-1:0]      vld_q, vld_d;
    logic [SW-1:0]         size_q, size_d;
    logic [PW-1:0]         min_ptr_q, min_ptr_d;
    logic [PW-1:0]         max_ptr_q, max_ptr_d;
    logic [PW-1:0]         scan_idx_q, scan_idx_d;
    logic                  scan_found_q, scan_found_d;
    logic                  valid_out_q, valid_out_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic [TAG_WIDTH-1:0]  tag_out_q, tag_out_d;

    logic [TAG_WIDTH-1:0]  tag_mem  [DEPTH];
    logic [DATA_WIDTH-1:0] data_mem [DEPTH];

    logic          enq_fire;
    logic          deq_fire;
    logic [PW-1:0] free_idx;
    logic [PW-1:0] deq_idx;

    assign empty_out     = (size_q == '0);
    assign full_out      = (size_q == SW'(DEPTH));
    assign enq_ready_out = (state_q == IDLE) && !full_out && !flush_in;
    assign deq_ready_out = (state_q == IDLE) && !empty_out && !flush_in;
    assign enq_fire      = enq_valid_in && enq_ready_out;
    assign deq_fire      = deq_valid_in && deq_ready_out;
    assign deq_idx       = deq_max_in ? max_ptr_q : min_ptr_q;

    assign valid_out   = valid_out_q;
    assign data_out    = data_out_q;
    assign tag_out     = tag_out_q;
    assign size_out    = size_q;
    assign busy_out    = (state_q == SCAN);
    assign min_tag_out = empty_out ? '0 : tag_mem[min_ptr_q];
    assign max_tag_out = empty_out ? '0 : tag_mem[max_ptr_q];

    // Lowest-index free slot; only meaningful when not full.
    always_comb begin
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!vld_q[i]) free_idx = PW'(i);
        end
    end

    always_comb begin
        // NOTE: every _d defaults to its _q first so no path leaves a variable unassigned (no latches).
        state_d      = state_q;
        vld_d        = vld_q;
        size_d       = size_q;
        min_ptr_d    = min_ptr_q;
        max_ptr_d    = max_ptr_q;
        scan_idx_d   = scan_idx_q;
        scan_found_d = scan_found_q;
        valid_out_d  = 1'b0;
        data_out_d   = data_out_q;
        tag_out_d    = tag_out_q;

        if (flush_in) begin
            state_d = IDLE;
            vld_d   = '0;
            size_d  = '0;
        end else if (state_q == IDLE) begin
            if (enq_fire) vld_d[free_idx] = 1'b1;
            if (deq_fire) begin
                vld_d[deq_idx] = 1'b0;
                data_out_d     = data_mem[deq_idx];
                tag_out_d      = tag_mem[deq_idx];
                valid_out_d    = 1'b1;
            end

            if (enq_fire && !deq_fire) begin
                size_d = size_q + SW'(1);
                if (empty_out) begin
                    min_ptr_d = free_idx;
                    max_ptr_d = free_idx;
                end else begin
                    if (enq_tag_in < tag_mem[min_ptr_q]) min_ptr_d = free_idx;
                    if (enq_tag_in > tag_mem[max_ptr_q]) max_ptr_d = free_idx;
                end
            end else if (deq_fire) begin
                // A simultaneous enqueue keeps size; either way a non-empty result triggers a rescan.
                if (!enq_fire) size_d = size_q - SW'(1);
                if (enq_fire || size_q != SW'(1)) begin
                    state_d      = SCAN;
                    scan_idx_d   = '0;
                    scan_found_d = 1'b0;
                end
            end
        end else begin
            if (vld_q[scan_idx_q]) begin
                if (!scan_found_q || tag_mem[scan_idx_q] < tag_mem[min_ptr_q]) min_ptr_d = scan_idx_q;
                if (!scan_found_q || tag_mem[scan_idx_q] > tag_mem[max_ptr_q]) max_ptr_d = scan_idx_q;
                scan_found_d = 1'b1;
            end
            if (scan_idx_q == PW'(DEPTH - 1)) state_d = IDLE;
            else                              scan_idx_d = scan_idx_q + PW'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q      <= IDLE;
            vld_q        <= '0;
            size_q       <= '0;
            min_ptr_q    <= '0;
            max_ptr_q    <= '0;
            scan_idx_q   <= '0;
            scan_found_q <= 1'b0;
            valid_out_q  <= 1'b0;
            data_out_q   <= '0;
            tag_out_q    <= '0;
        end else begin
            state_q      <= state_d;
            vld_q        <= vld_d;
            size_q       <= size_d;
            min_ptr_q    <= min_ptr_d;
            max_ptr_q    <= max_ptr_d;
            scan_idx_q   <= scan_idx_d;
            scan_found_q <= scan_found_d;
            valid_out_q  <= valid_out_d;
            data_out_q   <= data_out_d;
            tag_out_q    <= tag_out_d;
        end
    end

    // NOTE: slot payload/tag storage is not reset; the valid bits alone decide what is live.
    always_ff @(posedge clk_in) begin
        if (enq_fire) begin
            tag_mem[free_idx]  <= enq_tag_in;
            data_mem[free_idx] <= enq_data_in;
        end
    end

endmodule

// File: doc/depq_scan.md
DEPQ_SCAN -- requirements
Module: depq_scan

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, payload width.
REQ-002 SHALL have parameter TAG_WIDTH, default 32, unsigned priority tag width.
REQ-003 SHALL have parameter DEPTH, default 8, slot count (>=2).
REQ-004 SHALL have the following ports (W = $clog2(DEPTH)+1):
- clk_in  in  1  sole clock; all state changes on rising edge.
- rst_in  in  1  asynchronous, active-low reset.
- flush_in  in  1  synchronous clear of all contents.
- enq_valid_in  in  1  enqueue request.
- enq_ready_out  out  1  enqueue accepted when both valid and ready are high.
- enq_data_in  in  DATA_WIDTH  enqueue payload.
- enq_tag_in  in  TAG_WIDTH  enqueue priority.
- deq_valid_in  in  1  dequeue request.
- deq_max_in  in  1  0 = dequeue minimum tag, 1 = dequeue maximum tag.
- deq_ready_out  out  1  dequeue accepted when both valid and ready are high.
- valid_out  out  1  one-cycle pulse; data_out/tag_out hold the dequeued entry.
- data_out  out  DATA_WIDTH  dequeued payload, held until the next dequeue.
- tag_out  out  TAG_WIDTH  dequeued tag, held until the next dequeue.
- min_tag_out  out  TAG_WIDTH  current minimum tag.
- max_tag_out  out  TAG_WIDTH  current maximum tag.
- size_out  out  W  occupied slot count.
- empty_out  out  1  size_out==0, combinational.
- full_out  out  1  size_out==DEPTH, combinational.
- busy_out  out  1  high while state==SCAN.

Function
REQ-005 SHALL hold DEPTH slots, each with tag, data and valid bit; new entries go to the lowest-index free slot.
REQ-006 SHALL use the states IDLE and SCAN.
REQ-007 SHALL drive enq_ready_out = IDLE && !full_out && !flush_in.
REQ-008 SHALL drive deq_ready_out = IDLE && !empty_out && !flush_in.
REQ-009 SHALL keep registered min_ptr and max_ptr that are correct whenever in IDLE and not empty.
REQ-010 SHALL drive min_tag_out and max_tag_out from the slots at min_ptr/max_ptr, or 0 when empty.
REQ-011 On an accepted enqueue SHALL write the slot, set its valid bit and add 1 to size.
REQ-012 On an accepted enqueue into an empty queue SHALL point both min_ptr and max_ptr at the new slot.
REQ-013 On an accepted enqueue otherwise SHALL update min_ptr only if the new tag is strictly smaller, and max_ptr only if strictly larger.
REQ-014 On an accepted dequeue at edge k SHALL register the selected slot (min_ptr or max_ptr per deq_max_in) into data_out/tag_out, clear its valid bit, subtract 1 from size, and pulse valid_out for the cycle after edge k.
REQ-015 After a dequeue that leaves the queue non-empty SHALL enter SCAN at index 0 and examine one slot per cycle for DEPTH cycles.
REQ-016 During SCAN SHALL replace the running min/max only on strict compare, so ties resolve to the lowest slot index; SHALL return to IDLE on the edge that examines slot DEPTH-1.
REQ-017 After a dequeue that leaves the queue empty SHALL stay in IDLE with no scan.
REQ-018 Simultaneous enqueue and dequeue accepted in the same IDLE cycle SHALL both complete.
REQ-019 In that case the dequeue SHALL use the pre-enqueue pointers (the new entry cannot be dequeued that cycle), size SHALL be unchanged, and the following SCAN SHALL include the new entry.
REQ-020 SHALL accept no enqueue or dequeue during SCAN; minimum spacing between dequeues is DEPTH+1 cycles.
REQ-021 flush_in SHALL have priority over enqueue and dequeue.
REQ-022 flush_in, in any state, SHALL clear all valid bits, set size to 0, abort SCAN, enter IDLE on the next edge, and leave data_out/tag_out unchanged.
REQ-023 Width rule: size_out SHALL be W bits so that DEPTH is representable; tags compare as unsigned.

Reset
REQ-024 While rst_in is low (asynchronous), the block SHALL force state IDLE, clear all valid bits, and set size_out, data_out, tag_out, valid_out, min_tag_out, max_tag_out and busy_out to 0.
REQ-025 Under reset empty_out SHALL be 1, full_out 0, enq_ready_out 1 and deq_ready_out 0; reset asserted mid-SCAN SHALL take effect immediately.

Verification (DEPTH=4, TAG_WIDTH=8)
REQ-026 Release reset -> empty_out=1, size_out=0, enq_ready_out=1, deq_ready_out=0, busy_out=0.
REQ-027 Enqueue tags 5,2,9,7 -> size_out=4, full_out=1, enq_ready_out=0, min_tag_out=2, max_tag_out=9.
REQ-028 Dequeue min -> next cycle valid_out=1, tag_out=2; then busy_out=1 for 4 cycles; afterwards min_tag_out=5, max_tag_out=9, size_out=3.
REQ-029 Enqueue (tag3,data 0xA) then (tag3,data 0xB), dequeue min -> data_out=0xA; dequeue max after scan -> data_out=0xB.
REQ-030 Queue {4,6}, same-cycle enqueue tag 1 and dequeue min -> tag_out=4, size_out=2; after scan min_tag_out=1, max_tag_out=6.
REQ-031 flush_in during SCAN -> next cycle size_out=0, busy_out=0, empty_out=1; rst_in low mid-SCAN -> all outputs at reset values the same cycle.
